// File: rtl/adder_stream_stage.sv
// Valid/ready streaming wrapper around a ripple-carry nbits_adder. Operands are
// registered, the sum/carry lands in a 2-entry result FIFO, and carry-outs are counted.

module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module nbits_adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);
  logic [WIDTH:0] c;

  assign c[0]  = 1'b0;
  assign carry = c[WIDTH];

  // One bit cell per instance; the carry chain threads through the instance array.
  full_adder u_fa [WIDTH-1:0] (
    .a  (a),
    .b  (b),
    .ci (c[WIDTH-1:0]),
    .s  (sum),
    .co (c[WIDTH:1])
  );
endmodule

module adder_stream_stage #(
  parameter int WIDTH     = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_sum,
  output logic                 out_carry,
  output logic [CNT_WIDTH-1:0] ovf_count,
  input  logic                 ovf_clear
);
  typedef struct packed {
    logic             carry;
    logic [WIDTH-1:0] sum;
  } res_t;

  logic [WIDTH-1:0] op_a, op_b;
  logic             op_valid;

  res_t             push_data;
  res_t [1:0]       mem;
  logic             wr_ptr, rd_ptr;
  logic [1:0]       count;

  logic pop, fifo_can_push, advance, accept;

  nbits_adder #(.WIDTH(WIDTH)) u_add (
    .a     (op_a),
    .b     (op_b),
    .sum   (push_data.sum),
    .carry (push_data.carry)
  );

  assign out_valid     = (count != 2'd0);
  assign pop           = out_valid & out_ready;
  assign fifo_can_push = (count < 2'd2) | pop;
  assign advance       = op_valid & fifo_can_push;
  // in_ready follows out_ready combinationally so a full stage still streams.
  assign in_ready      = ~op_valid | fifo_can_push;
  assign accept        = in_valid & in_ready;

  assign out_sum   = mem[rd_ptr].sum;
  assign out_carry = mem[rd_ptr].carry;

  always_ff @(posedge clk) begin
    if (rst) begin
      op_a     <= '0;
      op_b     <= '0;
      op_valid <= 1'b0;
    end else if (accept) begin
      op_a     <= in_a;
      op_b     <= in_b;
      op_valid <= 1'b1;
    end else if (advance) begin
      op_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (advance) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      case ({advance, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Clear wins over a same-cycle increment; the counter sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst || ovf_clear)
      ovf_count <= '0;
    else if (advance && push_data.carry && (ovf_count != {CNT_WIDTH{1'b1}}))
      ovf_count <= ovf_count + 1'b1;
  end
endmodule

// File: tb/tb_adder_stream_stage.sv
// Randomized and directed checks of adder_stream_stage against a queue-based reference model.

module tb_adder_stream_stage;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0, out_ready = 1'b0, ovf_clear = 1'b0;
  logic [7:0] in_a = '0, in_b = '0;

  logic        in_ready, out_valid, out_carry;
  logic [7:0]  out_sum;
  logic [15:0] ovf_count;
  logic        in_ready_s, out_valid_s, out_carry_s;
  logic [7:0]  out_sum_s;
  logic [1:0]  ovf_count_s;

  adder_stream_stage #(.WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_carry(out_carry), .ovf_count(ovf_count), .ovf_clear(ovf_clear)
  );

  // Narrow-counter copy on the same stimulus, to reach saturation quickly.
  adder_stream_stage #(.WIDTH(8), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_s),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid_s), .out_ready(out_ready),
    .out_sum(out_sum_s), .out_carry(out_carry_s), .ovf_count(ovf_count_s), .ovf_clear(ovf_clear)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  // Reference model: items waiting in the operand stage and in the result queue.
  logic [8:0] q[$];
  logic [8:0] op_res;
  bit         op_full, just_rst, last_acc;
  int         ovf16, ovf2, n_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Called at posedge+1 with inputs already driven; checks, advances the model, waits one edge.
  task automatic step();
    bit pop, can_push, adv, acc;
    #2;
    pop      = out_ready && (q.size() > 0);
    can_push = (q.size() < 2) || pop;
    adv      = op_full && can_push;
    acc      = in_valid && (!op_full || can_push);
    chk("in_ready", in_ready, !op_full || can_push);
    chk("out_valid", out_valid, q.size() != 0);
    if (q.size() > 0) begin
      chk("out_sum", out_sum, q[0][7:0]);
      chk("out_carry", out_carry, q[0][8]);
    end else if (just_rst) begin
      chk("rst_sum", out_sum, 0);
      chk("rst_carry", out_carry, 0);
    end
    chk("ovf16", ovf_count, ovf16);
    chk("ovf2", ovf_count_s, ovf2);
    last_acc = 0;
    if (rst) begin
      q.delete();
      op_full  = 0;
      ovf16    = 0;
      ovf2     = 0;
      just_rst = 1;
    end else begin
      just_rst = 0;
      if (pop) void'(q.pop_front());
      if (ovf_clear) begin
        ovf16 = 0;
        ovf2  = 0;
      end else if (adv && op_res[8]) begin
        if (ovf16 < 65535) ovf16++;
        if (ovf2 < 3) ovf2++;
      end
      if (adv) q.push_back(op_res);
      if (acc) begin
        op_full  = 1;
        op_res   = {1'b0, in_a} + {1'b0, in_b};
        last_acc = 1;
        n_acc++;
      end else if (adv) begin
        op_full = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    step();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int idx, budget, target;
    int sat_seq[5];
    sat_seq = '{1, 2, 3, 3, 3};

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    q.delete();
    op_full = 0; ovf16 = 0; ovf2 = 0; n_acc = 0; just_rst = 1;

    // Reset state and single-transaction latency
    out_ready = 1'b1;
    send(8'h0F, 8'h01);
    idle(1);
    chk("t1_valid", out_valid, 1);
    chk("t1_sum", out_sum, 8'h10);
    chk("t1_carry", out_carry, 0);
    idle(2);

    // Back-to-back carries
    send(8'hFF, 8'h01);
    send(8'h80, 8'h80);
    idle(3);
    chk("t2_ovf", ovf_count, 2);

    // Backpressure: FIFO fills, third pair held, fourth waits for a pop
    idx = 0;
    for (int c = 0; c < 10; c++) begin
      out_ready = (c >= 4);
      if (idx < 4) begin
        in_valid = 1'b1;
        in_a = 8'(idx + 1);
        in_b = 8'(idx + 1);
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (last_acc) idx++;
      if (c == 3) chk("bp_in_ready", in_ready, 0);
    end
    chk("bp_all_accepted", idx, 4);

    // Saturation of the 2-bit counter, then clear beating a carry push
    ovf_clear = 1'b1;
    idle(1);
    ovf_clear = 1'b0;
    send(8'hFF, 8'h01);
    for (int k = 0; k < 5; k++) begin
      send(8'hFF, 8'h01);
      chk("sat_seq", ovf_count_s, sat_seq[k]);
    end
    in_valid  = 1'b0;
    ovf_clear = 1'b1;
    step();
    ovf_clear = 1'b0;
    chk("clr_prio_s", ovf_count_s, 0);
    chk("clr_prio", ovf_count, 0);
    idle(3);

    // Random streams
    target = n_acc + 10000;
    budget = 0;
    while (n_acc < target && budget < 60000) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      ovf_clear = ($urandom_range(0, 49) == 0);
      in_a      = 8'($urandom);
      in_b      = 8'($urandom);
      step();
      budget++;
    end
    chk("rand_budget", n_acc >= target, 1);
    ovf_clear = 1'b0;
    out_ready = 1'b1;
    idle(5);
    chk("drain_valid", out_valid, 0);

    // Reset with full FIFO and held operand
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'($urandom), 8'hF0);
    chk("full_in_ready", in_ready, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("post_rst_valid", out_valid, 0);
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_ovf", ovf_count, 0);
    out_ready = 1'b1;
    idle(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/adder_stream_stage.md
Name: adder_stream_stage

Overview:
- Streaming wrapper that sits directly upstream and downstream of the combinational nbits_adder.
- Accepts operand pairs over a valid/ready handshake and registers them to drive one internal nbits_adder instance.
- Captures the adder's sum and carry into a 2-entry output buffer, presented on a valid/ready result stream.
- Keeps a saturating count of carry-out (overflow) events for status.

Parameters:
- WIDTH, 8, operand/sum width; passed unchanged to the nbits_adder instance.
- CNT_WIDTH, 16, width of the overflow event counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand pair on in_a/in_b is valid.
- in_ready  output  1  stage can accept an operand pair this cycle.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B.
- out_valid  output  1  out_sum/out_carry hold a valid result.
- out_ready  input  1  downstream consumes the result this cycle.
- out_sum  output  WIDTH  sum of the oldest buffered result.
- out_carry  output  1  carry-out of the oldest buffered result.
- ovf_count  output  CNT_WIDTH  number of buffered results with carry=1, saturating.
- ovf_clear  input  1  synchronous clear of ovf_count.

Behaviour:
- Reset (rst=1 at an edge) clears all state:
  - op_valid=0; operand regs=0.
  - FIFO empty, pointers=0; ovf_count=0.
  - Outputs after the reset edge: in_ready=1, out_valid=0, out_sum=0, out_carry=0, ovf_count=0.
  - rst mid-operation discards the in-flight operand and all buffered results; nothing is emitted afterwards.
- Operand stage:
  - Registers op_a, op_b and op_valid.
  - op_a/op_b drive the nbits_adder a/b inputs.
  - Adder outputs {carry,sum} are the push data for the FIFO.
- Definitions:
  - pop = out_valid & out_ready.
  - fifo_can_push = (count<2) | pop.
  - advance = op_valid & fifo_can_push.
- Handshakes:
  - in_ready = ~op_valid | fifo_can_push. This is combinational from out_ready, as intended.
  - Accept when in_valid & in_ready: op regs load in_a/in_b and op_valid=1.
  - If advance occurs without an accept, op_valid falls to 0.
  - On advance, {carry,sum} is written into the FIFO at the write pointer.
- FIFO:
  - 2 entries; 1-bit pointers wrap 1->0; count 0..2.
  - Push and pop in the same cycle leave count unchanged, including when count=2.
  - out_valid = (count!=0); out_sum/out_carry show the read-pointer entry.
  - Entry contents are don't-care when empty, but must be 0 after reset.
- Latency:
  - Accept at edge k -> result pushed at edge k+1 -> out_valid=1 in cycle after k+1.
  - That is 2 edges minimum; no combinational input-to-output path on data.
- Throughput: 1 result/cycle sustained while out_ready=1.
- Ordering: strict FIFO order; no drop, no duplication.
- Backpressure with out_ready=0:
  - Two results fill the FIFO, and the third pair is held in the op stage.
  - in_ready=0 until a pop occurs.
  - in_a/in_b changes are ignored while in_ready=0.
- Arithmetic: {carry,sum} = a+b, modulo 2^WIDTH, with carry = bit WIDTH. There is no carry-in.
- Overflow counter:
  - Increments by 1 on each push whose carry=1.
  - Holds at 2^CNT_WIDTH-1 (no wrap).
  - ovf_clear=1 sets it to 0 and takes priority over a same-cycle increment.
- Invalid handshake: in_valid=0 with in_ready=1 leaves state unchanged.

Test Plan:
- WIDTH=8, out_ready=1: send (0x0F,0x01) -> 2 edges later out_valid=1, out_sum=0x10, out_carry=0, ovf_count=0.
- Send (0xFF,0x01) then (0x80,0x80) -> results 0x00/1 then 0x00/1 on consecutive cycles; ovf_count=2.
- out_ready=0; offer 4 pairs (1,1),(2,2),(3,3),(4,4) back-to-back -> first 3 accepted, in_ready=0 after the third. Then out_ready=1 -> outputs 2,4,6,8 in order on consecutive cycles, with the 4th pair accepted on the first pop cycle.
- CNT_WIDTH=2: push 5 carry-producing pairs -> ovf_count sequence 1,2,3,3,3. Then assert ovf_clear together with a carry push -> ovf_count=0.
- Random streams with random in_valid/out_ready, 10k pairs -> every output equals (a+b) mod 256 with the correct carry, in order, none lost.
- Fill the FIFO and op stage, then assert rst for 1 cycle -> next cycle out_valid=0, in_ready=1, ovf_count=0, and no stale result ever appears afterwards.
